// File: rtl/sipo_capture.sv
// Serial-in, parallel-out capture stage: shifts handshaked bits into a WIDTH-bit word
// and hands each completed word to a one-word output slot with its own handshake.
module sipo_capture #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    logic [WIDTH-1:0] w_sr_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_dout_next;
    logic             w_dout_valid_next;
    logic [WIDTH-1:0] w_shifted;
    logic             w_full;
    logic             w_slot_free;
    logic             w_accept;

    assign w_full      = (r_count == FULL_COUNT);
    assign w_slot_free = !r_dout_valid || dout_ready;
    assign w_accept    = din_valid && !w_full;
    assign w_shifted   = MSB_FIRST ? {r_sr[WIDTH-2:0], din} : {din, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr         <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_sr         <= w_sr_next;
            r_count      <= w_count_next;
            r_dout       <= w_dout_next;
            r_dout_valid <= w_dout_valid_next;
        end
    end

    // A consumed word drops valid unless a new word is loaded on the same edge.
    always_comb begin
        w_sr_next         = r_sr;
        w_count_next      = r_count;
        w_dout_next       = r_dout;
        w_dout_valid_next = r_dout_valid && !dout_ready;
        if (w_full) begin
            if (w_slot_free) begin
                w_dout_next       = r_sr;
                w_dout_valid_next = 1'b1;
                w_count_next      = '0;
            end
        end else if (w_accept) begin
            w_sr_next = w_shifted;
            if (r_count == LAST_COUNT) begin
                if (w_slot_free) begin
                    w_dout_next       = w_shifted;
                    w_dout_valid_next = 1'b1;
                    w_count_next      = '0;
                end else begin
                    w_count_next = FULL_COUNT;
                end
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end
    end

    assign din_ready  = !w_full;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign bit_count  = r_count;

endmodule
